// File: rtl/br_amba_iso_seq.sv
// br_amba_iso_seq: orders isolate/release of NumPorts upstream isolators; BR_AMBA_ISO_SEQ_TIMEOUT_EN adds a sticky step timeout
module br_amba_iso_seq #(
  parameter int NumPorts      = 2,
  parameter int TimeoutCycles = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                isolate_req_i,
  output logic                isolate_done_o,
  output logic                busy_o,
  output logic [NumPorts-1:0] port_isolate_req_o,
  input  logic [NumPorts-1:0] port_isolate_done_i,
  input  logic                clear_timeout_i,
  output logic                timeout_err_o
);
  localparam int IW = NumPorts > 1 ? $clog2(NumPorts) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(NumPorts - 1);
  typedef enum logic [1:0] {Idle, Isolating, Isolated, Releasing} state_e;
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NumPorts-1:0] req_q, req_d;
  logic done_sel;
  assign done_sel = |(port_isolate_done_i & (NumPorts'(1) << idx_q));
  // next state: requests grow as a thermometer going up, shrink from the top coming down
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    req_d   = req_q;
    case (state_q)
      Idle: if (isolate_req_i) begin
        state_d = Isolating;
        idx_d   = '0;
        req_d   = NumPorts'(1);
      end
      Isolating: if (done_sel) begin
        if (idx_q == LastIdx) state_d = Isolated;
        else begin
          idx_d = idx_q + 1'b1;
          req_d = NumPorts'({req_q, 1'b1});
        end
      end
      Isolated: if (!isolate_req_i) begin
        state_d = Releasing;
        idx_d   = LastIdx;
        req_d   = {NumPorts{1'b1}} >> 1;
      end
      Releasing: if (!done_sel) begin
        if (idx_q == '0) state_d = Idle;
        else begin
          idx_d = idx_q - 1'b1;
          req_d = req_q >> 1;
        end
      end
      default: state_d = Idle;
    endcase
  end
  // sequencer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= Idle;
      idx_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
    end
  end
  assign port_isolate_req_o = req_q;
  assign isolate_done_o     = state_q == Isolated;
  assign busy_o             = state_q == Isolating || state_q == Releasing;
`ifdef BR_AMBA_ISO_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TimeoutCycles + 1);
  logic [TW-1:0] timer_q, timer_d;
  logic err_q, err_d, step;
  assign step    = state_d != state_q || idx_d != idx_q || !busy_o;
  assign timer_d = step ? '0 : timer_q == TW'(TimeoutCycles) ? timer_q : timer_q + 1'b1;
  assign err_d   = timer_d == TW'(TimeoutCycles) || (err_q && !clear_timeout_i);
  // wait timer restarts on any progress; the error flag holds until cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end
  assign timeout_err_o = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = clear_timeout_i ^ (TimeoutCycles > 0);
  assign timeout_err_o  = 1'b0;
`endif
  a_state_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(state_q));
  a_req_therm: assert property (@(posedge clk) disable iff (!rst_n) (req_q & (req_q + 1'b1)) == '0);
  a_done_all: assert property (@(posedge clk) disable iff (!rst_n) isolate_done_o |-> &req_q);
endmodule

// File: doc/br_amba_iso_seq.md
Name: br_amba_iso_seq

Overview:
- Sequencer that isolates and restores several AXI upstream isolators in a fixed order from a single system-level isolate request.
- Sits between the power/reset controller and NumPorts upstream isolator FSMs; drives each isolator's isolate_req and observes its isolate_done.
- Isolation proceeds one port at a time in ascending index order; release proceeds in descending order. Reports a single aggregated isolate_done.

Parameters:
- NumPorts, 2, number of sequenced isolators; must be >= 1.
- TimeoutCycles, 1024, wait-cycle limit per step before timeout_err is flagged; must be >= 1. Used only with the optional feature.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- isolate_req  input  1  system request to isolate all ports; level.
- isolate_done  output  1  all ports isolated; level.
- busy  output  1  sequencing in progress (Isolating or Releasing).
- port_isolate_req  output  NumPorts  per-port isolate request to isolator FSMs.
- port_isolate_done  input  NumPorts  per-port isolate_done from isolator FSMs.
- clear_timeout  input  1  clears sticky timeout_err.
- timeout_err  output  1  sticky step-timeout flag.

Behaviour:
- Reset: state=Idle, idx=0, port_isolate_req=0, isolate_done=0, busy=0, timeout_err=0, timer=0. All state flops are asynchronously reset on rst_n low.
- idx width: $clog2(NumPorts), minimum 1 bit. port_isolate_req is registered. Bit k is 1 iff port k is requested.
- Idle:
  - All outputs 0.
  - isolate_req=1 -> Isolating, idx=0, port_isolate_req[0] set.
  - Latency: req sampled at cycle N -> port_isolate_req[0]=1 at N+1.
- Isolating (busy=1):
  - Bits [0..idx] set.
  - port_isolate_done[idx]=1 and idx<NumPorts-1 -> idx+1, set bit idx+1 next cycle.
  - port_isolate_done[idx]=1 and idx=NumPorts-1 -> Isolated.
  - No abort: isolate_req deasserting here has no effect until Isolated is reached.
- Isolated:
  - isolate_done=1, busy=0, all bits set.
  - isolate_req=0 -> Releasing, idx=NumPorts-1, bit idx cleared next cycle.
- Releasing (busy=1, isolate_done=0):
  - Bits [0..idx-1] set; bit idx clear.
  - port_isolate_done[idx]=0 and idx>0 -> idx-1, clear that bit.
  - port_isolate_done[idx]=0 and idx=0 -> Idle.
  - isolate_req reasserting here is ignored until Idle is reached; Idle then re-enters Isolating on the following cycle.
- NumPorts=1: Isolating and Releasing each take exactly one step.
- port_isolate_done bits other than idx are ignored. No check is made that they stay stable.
- isolate_done deasserts the cycle Releasing is entered. This is required so downstream logic never sees "done" during restore.
- Assertions:
  - state is always known.
  - port_isolate_req is always a thermometer code (contiguous ones from bit 0).
  - isolate_done implies port_isolate_req is all ones.

Optional Feature:
- Macro: BR_AMBA_ISO_SEQ_TIMEOUT_EN.
- Defined:
  - Timer counts cycles spent waiting in Isolating or Releasing. It clears on every idx change and on every state change.
  - Timer saturates at TimeoutCycles.
  - When timer reaches TimeoutCycles, timeout_err is set and stays set (sticky). Sequencing keeps waiting; no step is skipped.
  - clear_timeout=1 clears timeout_err next cycle. If set and clear occur in the same cycle, set wins.
- Not defined: timer is absent, timeout_err is tied 0, clear_timeout is unused (lint-waived).

Test Plan:
- Basic sequence, NumPorts=2:
  - Raise isolate_req at cycle 0 -> port_isolate_req=2'b01 at cycle 1.
  - Drive done[0] at cycle 3 -> 2'b11 at cycle 4.
  - Drive done[1] at cycle 6 -> isolate_done=1 at cycle 7.
- Release order: from Isolated, drop isolate_req -> port_isolate_req=2'b01 next cycle and isolate_done=0. Drop done[1] -> 2'b00. Drop done[0] -> Idle, busy=0.
- No-abort: drop isolate_req while waiting on port 0 -> sequencing continues through Isolated for one cycle (isolate_done pulses 1), then enters Releasing.
- Reset mid-operation: assert rst_n=0 during Releasing with port_isolate_req=2'b01 -> all outputs 0 immediately (asynchronous). After release from reset, state is Idle.
- Timeout, macro defined, TimeoutCycles=4: withhold done[0] -> timeout_err=1 after 4 wait cycles. Drive done[0] -> sequencing continues and timeout_err stays 1. Pulse clear_timeout -> timeout_err=0.
- Timeout, macro undefined: withhold done[0] for 2000 cycles -> timeout_err remains 0 and port_isolate_req stays 2'b01.
